// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment scan controller with iterative binary-to-BCD conversion
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   Funct_Select         1 = show value_a/dp_a, 0 = show value_b/dp_b (sampled once per frame)
//   value_a, value_b     unsigned DATA_W-bit sources
//   dp_a, dp_b           decimal-point masks, bit i aligns with anode_n[i]
//   C_Digit              BCD code of the active digit, 4'hF = blank
//   anode_n              active-low digit enables, idx 0 (MSD) on bit N_DIGITS-1
//   dp_n                 active-low decimal point of the active digit
//   ovf                  displayed value is saturated to all 9s
module display_scan_ctrl #(
   parameter int N_DIGITS   = 4,
   parameter int DATA_W     = 14,
   parameter int SCAN_DIV   = 50000,
   parameter int LEAD_BLANK = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                Funct_Select,
   input  logic [DATA_W-1:0]   value_a,
   input  logic [DATA_W-1:0]   value_b,
   input  logic [N_DIGITS-1:0] dp_a,
   input  logic [N_DIGITS-1:0] dp_b,
   output logic [3:0]          C_Digit,
   output logic [N_DIGITS-1:0] anode_n,
   output logic                dp_n,
   output logic                ovf
);
   localparam int BW = 4 * N_DIGITS;
   localparam int DW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(N_DIGITS);
   localparam int CW = $clog2(DATA_W + 1);

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   localparam logic [63:0] LIMIT = pow10(N_DIGITS);

   if (SCAN_DIV < DATA_W + 2) begin : g_scan_chk
      $error("display_scan_ctrl: SCAN_DIV must be at least DATA_W+2");
   end
   if (N_DIGITS < 2 || DATA_W > 4 * N_DIGITS) begin : g_size_chk
      $error("display_scan_ctrl: need N_DIGITS >= 2 and DATA_W <= 4*N_DIGITS");
   end

   typedef enum logic [1:0] {IDLE, LOAD, CONVERT, COMMIT} state_t;

   state_t              state_q, state_d;
   logic                first_q, first_d;
   logic [DW-1:0]       div_q, div_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [DATA_W-1:0]   val_q, val_d;
   logic [BW-1:0]       bcd_q, bcd_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_DIGITS-1:0] dps_q, dps_d;
   logic                ovfs_q, ovfs_d;
   logic [BW-1:0]       sh_dig_q, sh_dig_d;
   logic [N_DIGITS-1:0] sh_dp_q, sh_dp_d;
   logic                sh_ovf_q, sh_ovf_d;
   logic [BW-1:0]       disp_dig_q, disp_dig_d;
   logic [N_DIGITS-1:0] disp_dp_q, disp_dp_d;
   logic                disp_ovf_q, disp_ovf_d;
   logic [3:0]          c_digit_q, c_digit_d;
   logic [N_DIGITS-1:0] anode_n_q, anode_n_d;
   logic                dp_n_q, dp_n_d;
   logic                ovf_q, ovf_d;

   logic                tc, wrap, lead;
   logic [IW-1:0]       ridx;
   logic [BW-1:0]       adj;
   logic [DATA_W-1:0]   sel_v;
   logic [N_DIGITS-1:0] sel_dp;

   always_comb begin
      tc         = div_q == DW'(SCAN_DIV - 1);
      wrap       = tc && idx_q == IW'(N_DIGITS - 1);
      div_d      = tc ? '0 : div_q + 1'b1;
      idx_d      = tc ? (wrap ? '0 : idx_q + 1'b1) : idx_q;
      // nibble/dp position of the active digit (idx 0 is the most significant)
      ridx       = IW'(N_DIGITS - 1) - idx_q;
      sel_v      = Funct_Select ? value_a : value_b;
      sel_dp     = Funct_Select ? dp_a : dp_b;
      state_d    = state_q;
      first_d    = first_q;
      val_d      = val_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      dps_d      = dps_q;
      ovfs_d     = ovfs_q;
      sh_dig_d   = sh_dig_q;
      sh_dp_d    = sh_dp_q;
      sh_ovf_d   = sh_ovf_q;
      // the shadow is published only at frame wrap so the display never changes mid-frame
      disp_dig_d = wrap ? sh_dig_q : disp_dig_q;
      disp_dp_d  = wrap ? sh_dp_q : disp_dp_q;
      disp_ovf_d = wrap ? sh_ovf_q : disp_ovf_q;
      adj        = bcd_q;
      lead       = (LEAD_BLANK != 0) && !ovfs_q;
      case (state_q)
         IDLE: begin
            if (wrap || first_q) begin
               state_d = LOAD;
               first_d = 1'b0;
            end
         end
         LOAD: begin
            dps_d = sel_dp;
            cnt_d = '0;
            if (64'(sel_v) >= LIMIT) begin
               bcd_d   = {N_DIGITS{4'h9}};
               ovfs_d  = 1'b1;
               state_d = COMMIT;
            end else begin
               bcd_d   = '0;
               val_d   = sel_v;
               ovfs_d  = 1'b0;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            for (int k = 0; k < N_DIGITS; k++)
               adj[4*k +: 4] = adj[4*k +: 4] >= 4'd5 ? adj[4*k +: 4] + 4'd3 : adj[4*k +: 4];
            bcd_d   = {adj[BW-2:0], val_q[DATA_W-1]};
            val_d   = val_q << 1;
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(DATA_W - 1) ? COMMIT : CONVERT;
         end
         default: begin
            // blanking stops at the first nonzero digit, the decimal-point digit, or the LSD
            for (int k = N_DIGITS - 1; k >= 0; k--) begin
               if (bcd_q[4*k +: 4] != 4'd0 || k == 0 || dps_q[k]) lead = 1'b0;
               sh_dig_d[4*k +: 4] = lead ? 4'hF : bcd_q[4*k +: 4];
            end
            sh_dp_d  = dps_q;
            sh_ovf_d = ovfs_q;
            state_d  = IDLE;
         end
      endcase
      c_digit_d = disp_dig_q[{ridx, 2'b00} +: 4];
      anode_n_d = ~(N_DIGITS'(1) << ridx);
      dp_n_d    = ~disp_dp_q[ridx];
      ovf_d     = disp_ovf_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         first_q    <= 1'b1;
         div_q      <= '0;
         idx_q      <= '0;
         val_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         dps_q      <= '0;
         ovfs_q     <= 1'b0;
         sh_dig_q   <= '1;
         sh_dp_q    <= '0;
         sh_ovf_q   <= 1'b0;
         disp_dig_q <= '1;
         disp_dp_q  <= '0;
         disp_ovf_q <= 1'b0;
         c_digit_q  <= 4'hF;
         anode_n_q  <= '1;
         dp_n_q     <= 1'b1;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         div_q      <= div_d;
         idx_q      <= idx_d;
         val_q      <= val_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         dps_q      <= dps_d;
         ovfs_q     <= ovfs_d;
         sh_dig_q   <= sh_dig_d;
         sh_dp_q    <= sh_dp_d;
         sh_ovf_q   <= sh_ovf_d;
         disp_dig_q <= disp_dig_d;
         disp_dp_q  <= disp_dp_d;
         disp_ovf_q <= disp_ovf_d;
         c_digit_q  <= c_digit_d;
         anode_n_q  <= anode_n_d;
         dp_n_q     <= dp_n_d;
         ovf_q      <= ovf_d;
      end
   end

   assign C_Digit = c_digit_q;
   assign anode_n = anode_n_q;
   assign dp_n    = dp_n_q;
   assign ovf     = ovf_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: scoreboard bench for display_scan_ctrl with N=4, DATA_W=14, SCAN_DIV=20
module tb_display_scan_ctrl;
   localparam int SD = 20;

   typedef struct packed {
      logic        fs;
      logic [13:0] a;
      logic [13:0] b;
      logic [3:0]  dpa;
      logic [3:0]  dpb;
      logic [15:0] dig;
      logic [3:0]  dp;
      logic        ov;
   } vec_t;

   typedef struct packed {
      logic [3:0] dig;
      logic [3:0] an;
      logic       dpn;
      logic       ov;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        Funct_Select;
   logic [13:0] value_a, value_b;
   logic [3:0]  dp_a, dp_b;
   logic [3:0]  C_Digit;
   logic [3:0]  anode_n;
   logic        dp_n, ovf;

   exp_t q[$];
   vec_t vecs[11];
   vec_t vrst;
   logic mon_en = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;

   display_scan_ctrl #(.N_DIGITS(4), .DATA_W(14), .SCAN_DIV(SD), .LEAD_BLANK(1)) dut (
      .clk(clk), .rst(rst), .Funct_Select(Funct_Select),
      .value_a(value_a), .value_b(value_b), .dp_a(dp_a), .dp_b(dp_b),
      .C_Digit(C_Digit), .anode_n(anode_n), .dp_n(dp_n), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic push_frame(input logic [15:0] dig, input logic [3:0] dp, input logic ov);
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         e.dig = dig[4*(3-i) +: 4];
         e.an  = ~(4'b1000 >> i);
         e.dpn = ~dp[3-i];
         e.ov  = ov;
         q.push_back(e);
      end
   endtask

   task automatic apply(input vec_t v);
      Funct_Select = v.fs;
      value_a      = v.a;
      value_b      = v.b;
      dp_a         = v.dpa;
      dp_b         = v.dpb;
   endtask

   task automatic check_reset(input string tag);
      check({tag, " anode_n"}, 32'(anode_n), 32'hF);
      check({tag, " C_Digit"}, 32'(C_Digit), 32'hF);
      check({tag, " dp_n"}, 32'(dp_n), 32'h1);
      check({tag, " ovf"}, 32'(ovf), 32'h0);
   endtask

   task automatic wait_drain(input string tag);
      int t = 0;
      while (q.size() != 0 && t < 600) begin
         @(negedge clk);
         t++;
      end
      check({tag, " pending slots"}, 32'(q.size()), 32'h0);
   endtask

   initial begin : monitor
      logic [3:0] prev_an = 4'hF;
      int   cyc = 0, last_cyc = 0;
      bit   last_ok = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) last_ok = 0;
         else if (anode_n != prev_an && anode_n != 4'hF) begin
            if (mon_en) begin
               if (last_ok) check("dwell", 32'(cyc - last_cyc), 32'(SD));
               if (q.size() == 0) check("unexpected slot anode_n", 32'(anode_n), 32'hF);
               else begin
                  e = q.pop_front();
                  check($sformatf("slot an=%b {dig,an,dpn,ovf}", e.an),
                        32'({C_Digit, anode_n, dp_n, ovf}), 32'(e));
               end
            end
            last_ok  = 1;
            last_cyc = cyc;
         end
         prev_an = anode_n;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      vecs[0]  = '{1'b1, 14'd1234,  14'd0,     4'b0000, 4'b0000, 16'h1234, 4'b0000, 1'b0};
      vecs[1]  = '{1'b0, 14'd1234,  14'd7,     4'b0000, 4'b0100, 16'hF007, 4'b0100, 1'b0};
      vecs[2]  = '{1'b0, 14'd1234,  14'd7,     4'b0000, 4'b0000, 16'hFFF7, 4'b0000, 1'b0};
      vecs[3]  = '{1'b1, 14'd12345, 14'd7,     4'b0000, 4'b0000, 16'h9999, 4'b0000, 1'b1};
      vecs[4]  = '{1'b1, 14'd9999,  14'd7,     4'b0000, 4'b0000, 16'h9999, 4'b0000, 1'b0};
      vecs[5]  = '{1'b1, 14'd42,    14'd315,   4'b0000, 4'b0000, 16'hFF42, 4'b0000, 1'b0};
      vecs[6]  = '{1'b0, 14'd42,    14'd315,   4'b0000, 4'b0000, 16'hF315, 4'b0000, 1'b0};
      vecs[7]  = '{1'b1, 14'd0,     14'd315,   4'b0000, 4'b0000, 16'hFFF0, 4'b0000, 1'b0};
      vecs[8]  = '{1'b0, 14'd0,     14'd10000, 4'b0000, 4'b0000, 16'h9999, 4'b0000, 1'b1};
      vecs[9]  = '{1'b1, 14'd1005,  14'd0,     4'b0001, 4'b0000, 16'h1005, 4'b0001, 1'b0};
      vecs[10] = '{1'b1, 14'd5,     14'd0,     4'b1000, 4'b0000, 16'h0005, 4'b1000, 1'b0};
      vrst     = '{1'b0, 14'd0,     14'd315,   4'b0000, 4'b0010, 16'hF315, 4'b0010, 1'b0};
      rst = 1'b1;
      apply(vecs[7]);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      repeat (30) @(negedge clk);
      apply(vecs[0]);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset mid-scan");
      q.delete();
      push_frame(16'hFFFF, 4'b0000, 1'b0);
      push_frame(vecs[0].dig, vecs[0].dp, vecs[0].ov);
      mon_en = 1'b1;
      rst = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      for (int i = 1; i < 11; i++) begin
         apply(vecs[i]);
         push_frame(vecs[i].dig, vecs[i].dp, vecs[i].ov);
         if (i < 10) repeat (4 * SD) @(negedge clk);
      end
      wait_drain("scan sequence");
      mon_en = 1'b0;
      begin
         int t = 0;
         while (anode_n != 4'b1110 && t < 200) begin @(negedge clk); t++; end
         while (anode_n != 4'b0111 && t < 200) begin @(negedge clk); t++; end
         check("frame start found", 32'(anode_n), 32'h7);
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset("reset in convert");
      @(negedge clk);
      apply(vrst);
      q.delete();
      push_frame(16'hFFFF, 4'b0000, 1'b0);
      push_frame(vrst.dig, vrst.dp, vrst.ov);
      mon_en = 1'b1;
      rst = 1'b0;
      wait_drain("after convert reset");
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
